// File: rtl/key_entry_sequencer_pkg.sv
// Shared definitions for the key entry sequencer: FSM state encoding,
// phase display width and the default debounce period.
package key_entry_pkg;

  localparam int PHASE_W = 2;

  // 10 ms at 50 MHz
  localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;

  typedef enum logic [PHASE_W-1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    OFFER  = 2'd2,
    LOADED = 2'd3
  } state_t;

endpackage

// File: rtl/key_entry_sequencer_if.sv
// Operand handshake bundle between the key entry sequencer (master) and
// the adder datapath (slave).
interface key_entry_sequencer_if #(
  parameter int WIDTH = 8
);

  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_valid;
  logic             op_ready;

  modport master (
    output op_a,
    output op_b,
    output op_valid,
    input  op_ready
  );

  modport slave (
    input  op_a,
    input  op_b,
    input  op_valid,
    output op_ready
  );

endinterface

// File: rtl/key_entry_sequencer_debounce.sv
// Pushbutton conditioner: two-flop synchronizer, stability counter and a
// registered single-cycle pulse on each accepted press (debounced 1->0).
module key_debounce
  import key_entry_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic press
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  generate
    if (DEBOUNCE_CYCLES < 2) begin : g_bad_param
      $error("key_debounce: DEBOUNCE_CYCLES must be at least 2");
    end
  endgenerate

  logic             sync1;
  logic             sync2;
  logic             level;
  logic [CNT_W-1:0] count;
  logic             press_reg;
  logic             differ;
  logic             expire;

  // The level flips on the cycle the input has differed for the full period.
  assign differ = (sync2 != level);
  assign expire = differ && (count == CNT_LAST);
  assign press  = press_reg;

  // Bring the asynchronous key into the clk domain; idle level is released (1).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
    end
  end

  // Count consecutive differing cycles; any matching cycle restarts the count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level <= 1'b1;
      count <= '0;
    end else if (!differ) begin
      count <= '0;
    end else if (expire) begin
      level <= sync2;
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

  // Pulse only when the accepted level goes to pressed; release is silent.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      press_reg <= 1'b0;
    end else begin
      press_reg <= expire && !sync2;
    end
  end

endmodule

// File: rtl/key_entry_sequencer.sv
// Key entry sequencer: the first accepted press loads operand A, the next
// loads operand B and offers the pair; later presses reload B only.
module key_entry_sequencer
  import key_entry_pkg::*;
#(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               key_n,
  input  logic [WIDTH-1:0]   sw,
  key_entry_sequencer_if.master op,
  output logic [PHASE_W-1:0] phase
);

  logic             press;
  state_t           state_reg;
  state_t           state_next;
  logic [WIDTH-1:0] op_a_reg;
  logic [WIDTH-1:0] op_a_next;
  logic [WIDTH-1:0] op_b_reg;
  logic [WIDTH-1:0] op_b_next;
  logic             valid_reg;
  logic             valid_next;

  key_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk   (clk),
    .reset (reset),
    .key_n (key_n),
    .press (press)
  );

  assign op.op_a     = op_a_reg;
  assign op.op_b     = op_b_reg;
  assign op.op_valid = valid_reg;
  assign phase       = state_reg;

  // State and operand registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= LOAD_A;
      op_a_reg  <= '0;
      op_b_reg  <= '0;
      valid_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      op_a_reg  <= op_a_next;
      op_b_reg  <= op_b_next;
      valid_reg <= valid_next;
    end
  end

  // Next-state and operand update; presses during OFFER are dropped so the
  // offered pair stays stable until the consumer takes it.
  always_comb begin
    state_next = state_reg;
    op_a_next  = op_a_reg;
    op_b_next  = op_b_reg;
    valid_next = valid_reg;
    unique case (state_reg)
      LOAD_A: begin
        if (press) begin
          op_a_next  = sw;
          state_next = LOAD_B;
        end
      end
      LOAD_B, LOADED: begin
        if (press) begin
          op_b_next  = sw;
          valid_next = 1'b1;
          state_next = OFFER;
        end
      end
      OFFER: begin
        if (valid_reg && op.op_ready) begin
          valid_next = 1'b0;
          state_next = LOADED;
        end
      end
      default: begin
        state_next = LOAD_A;
      end
    endcase
  end

endmodule

// File: tb/tb_key_entry_sequencer.sv
// Directed bench for key_entry_sequencer with a 4-cycle debounce period.
module tb_key_entry_sequencer;

  localparam int WIDTH = 8;
  localparam int DEB   = 4;

  logic             clk;
  logic             reset;
  logic             key_n;
  logic [WIDTH-1:0] sw;
  logic [1:0]       phase;

  int checks;
  int failures;

  key_entry_sequencer_if #(.WIDTH(WIDTH)) op_bus ();

  key_entry_sequencer #(
    .WIDTH           (WIDTH),
    .DEBOUNCE_CYCLES (DEB)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .key_n (key_n),
    .sw    (sw),
    .op    (op_bus.master),
    .phase (phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hold the key long enough for one accepted press, then release and settle.
  task automatic press_key(input logic [WIDTH-1:0] v);
    sw    = v;
    key_n = 1'b0;
    repeat (12) @(negedge clk);
    key_n = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    key_n = 1'b0;
    sw    = 8'h11;
    op_bus.op_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (op_bus.op_a !== 8'h00 || op_bus.op_b !== 8'h00 || op_bus.op_valid !== 1'b0 || phase !== 2'd0) begin
      failures++;
      $display("FAIL reset_state: op_a=%h op_b=%h valid=%b phase=%0d, required 00 00 0 0",
               op_bus.op_a, op_bus.op_b, op_bus.op_valid, phase);
    end
    reset = 1'b0;
    repeat (6) @(negedge clk);
    checks++;
    if (op_bus.op_a !== 8'h00) begin
      failures++;
      $display("FAIL reset_early_press: op_a=%h after 6 cycles, required 00", op_bus.op_a);
    end
    @(negedge clk);
    checks++;
    if (op_bus.op_a !== 8'h11 || phase !== 2'd1) begin
      failures++;
      $display("FAIL reset_held_press: op_a=%h phase=%0d after 7 cycles, required 11 1", op_bus.op_a, phase);
    end
    $display("txn reset: op_a=%h phase=%0d", op_bus.op_a, phase);
    key_n = 1'b1;
    repeat (12) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_first_pair;
    sw    = 8'h3C;
    key_n = 1'b0;
    repeat (6) @(negedge clk);
    checks++;
    if (op_bus.op_a !== 8'h00 || phase !== 2'd0) begin
      failures++;
      $display("FAIL press_latency_early: op_a=%h phase=%0d, required 00 0", op_bus.op_a, phase);
    end
    @(negedge clk);
    checks++;
    if (op_bus.op_a !== 8'h3C || phase !== 2'd1 || op_bus.op_valid !== 1'b0) begin
      failures++;
      $display("FAIL load_a: op_a=%h phase=%0d valid=%b, required 3c 1 0", op_bus.op_a, phase, op_bus.op_valid);
    end
    key_n = 1'b1;
    repeat (12) @(negedge clk);
    press_key(8'hA5);
    checks++;
    if (op_bus.op_b !== 8'hA5 || op_bus.op_valid !== 1'b1 || phase !== 2'd2) begin
      failures++;
      $display("FAIL load_b: op_b=%h valid=%b phase=%0d, required a5 1 2", op_bus.op_b, op_bus.op_valid, phase);
    end
    op_bus.op_ready = 1'b1;
    @(negedge clk);
    op_bus.op_ready = 1'b0;
    checks++;
    if (op_bus.op_valid !== 1'b0 || phase !== 2'd3) begin
      failures++;
      $display("FAIL first_transfer: valid=%b phase=%0d, required 0 3", op_bus.op_valid, phase);
    end
    $display("txn first_pair: op_a=%h op_b=%h phase=%0d", op_bus.op_a, op_bus.op_b, phase);
  endtask

  task automatic test_bounce;
    sw = 8'h77;
    for (int i = 0; i < 10; i++) begin
      key_n = ~key_n;
      repeat (2) @(negedge clk);
    end
    checks++;
    if (phase !== 2'd3 || op_bus.op_b !== 8'hA5) begin
      failures++;
      $display("FAIL bounce_reject: phase=%0d op_b=%h, required 3 a5", phase, op_bus.op_b);
    end
    key_n = 1'b0;
    repeat (20) @(negedge clk);
    checks++;
    if (phase !== 2'd2 || op_bus.op_b !== 8'h77 || op_bus.op_valid !== 1'b1) begin
      failures++;
      $display("FAIL bounce_capture: phase=%0d op_b=%h valid=%b, required 2 77 1", phase, op_bus.op_b, op_bus.op_valid);
    end
    op_bus.op_ready = 1'b1;
    @(negedge clk);
    op_bus.op_ready = 1'b0;
    sw = 8'h99;
    repeat (30) @(negedge clk);
    checks++;
    if (phase !== 2'd3 || op_bus.op_b !== 8'h77) begin
      failures++;
      $display("FAIL held_no_repeat: phase=%0d op_b=%h, required 3 77", phase, op_bus.op_b);
    end
    key_n = 1'b1;
    repeat (12) @(negedge clk);
    $display("txn bounce: op_b=%h phase=%0d", op_bus.op_b, phase);
  endtask

  task automatic test_backpressure;
    op_bus.op_ready = 1'b0;
    press_key(8'hA5);
    press_key(8'hFF);
    repeat (26) @(negedge clk);
    checks++;
    if (op_bus.op_b !== 8'hA5 || op_bus.op_valid !== 1'b1 || phase !== 2'd2) begin
      failures++;
      $display("FAIL backpressure_hold: op_b=%h valid=%b phase=%0d, required a5 1 2", op_bus.op_b, op_bus.op_valid, phase);
    end
    op_bus.op_ready = 1'b1;
    #1;
    checks++;
    if (op_bus.op_valid !== 1'b1 || op_bus.op_b !== 8'hA5 || op_bus.op_a !== 8'h3C) begin
      failures++;
      $display("FAIL transfer_data: valid=%b op_a=%h op_b=%h, required 1 3c a5", op_bus.op_valid, op_bus.op_a, op_bus.op_b);
    end
    @(negedge clk);
    op_bus.op_ready = 1'b0;
    checks++;
    if (op_bus.op_valid !== 1'b0 || phase !== 2'd3) begin
      failures++;
      $display("FAIL backpressure_release: valid=%b phase=%0d, required 0 3", op_bus.op_valid, phase);
    end
    $display("txn backpressure: op_b=%h phase=%0d", op_bus.op_b, phase);
  endtask

  task automatic test_reload_b;
    int valid_cycles;
    valid_cycles = 0;
    op_bus.op_ready = 1'b1;
    sw    = 8'h01;
    key_n = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (i == 20) key_n = 1'b1;
      @(negedge clk);
      if (op_bus.op_valid === 1'b1) valid_cycles++;
    end
    op_bus.op_ready = 1'b0;
    checks++;
    if (valid_cycles != 1) begin
      failures++;
      $display("FAIL reload_valid_width: valid high %0d cycles, required 1", valid_cycles);
    end
    checks++;
    if (op_bus.op_b !== 8'h01 || op_bus.op_a !== 8'h3C || phase !== 2'd3) begin
      failures++;
      $display("FAIL reload_b: op_a=%h op_b=%h phase=%0d, required 3c 01 3", op_bus.op_a, op_bus.op_b, phase);
    end
    $display("txn reload_b: op_a=%h op_b=%h phase=%0d", op_bus.op_a, op_bus.op_b, phase);
  endtask

  task automatic test_reset_mid_offer;
    press_key(8'h42);
    checks++;
    if (phase !== 2'd2 || op_bus.op_valid !== 1'b1 || op_bus.op_b !== 8'h42) begin
      failures++;
      $display("FAIL reoffer: phase=%0d valid=%b op_b=%h, required 2 1 42", phase, op_bus.op_valid, op_bus.op_b);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (op_bus.op_a !== 8'h00 || op_bus.op_b !== 8'h00 || op_bus.op_valid !== 1'b0 || phase !== 2'd0) begin
      failures++;
      $display("FAIL async_reset: op_a=%h op_b=%h valid=%b phase=%0d, required 00 00 0 0",
               op_bus.op_a, op_bus.op_b, op_bus.op_valid, phase);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    $display("txn reset_mid_offer: phase=%0d", phase);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_first_pair();
    test_bounce();
    test_backpressure();
    test_reload_b();
    test_reset_mid_offer();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/key_entry_sequencer.md
# key_entry_sequencer

Front end for the two-operand adder datapath: turns a raw pushbutton and the slide switches into clean, handshaked operand loads. A press first captures operand A, the next press captures operand B and offers the pair downstream, and later presses reload B only. It drives the operand side of the adder interface, replacing direct use of a KEY line as a clock.

## Interface

Parameters:

- `WIDTH`, 8, operand width in bits.
- `DEBOUNCE_CYCLES`, 500000, number of consecutive stable `clk` cycles needed to accept a key level (10 ms at 50 MHz). Must be ≥ 2.

Ports:

- `clk`  in  1  system clock; the only clock.
- `reset`  in  1  asynchronous, active-high reset.
- `key_n`  in  1  raw pushbutton; active-low and asynchronous to `clk`.
- `sw`  in  WIDTH  operand value sampled on an accepted press.
- `op_a`  out  WIDTH  registered operand A.
- `op_b`  out  WIDTH  registered operand B.
- `op_valid`  out  1  operand pair offered to the consumer.
- `op_ready`  in  1  consumer accepts the pair.
- `phase`  out  2  current FSM state encoding, for LED display.

## Operation

Key conditioning:

- `key_n` passes through a two-flop synchronizer.
- The debounced level changes only after the synchronized input differs from it for `DEBOUNCE_CYCLES` consecutive cycles.
- Any cycle that matches the current level clears the counter.
- A press event is a single-cycle pulse on the debounced 1→0 transition. Release generates no event.

FSM states (shared package encoding): LOAD_A=0, LOAD_B=1, OFFER=2, LOADED=3.

- LOAD_A, on press: `op_a` ← `sw`, then go to LOAD_B.
- LOAD_B, on press: `op_b` ← `sw`, `op_valid` ← 1, then go to OFFER.
- OFFER: `op_valid` stays 1 and `op_a`/`op_b` stay stable until a cycle with `op_ready`=1. Then `op_valid` ← 0 and go to LOADED.
  - A press during OFFER is dropped. It is not queued, and it does not change `op_b`.
- LOADED, on press: `op_b` ← `sw`, `op_valid` ← 1, then go to OFFER. `op_a` is kept.
- `op_valid`/`op_ready` follow the standard valid/ready rule: a transfer occurs on any rising edge where both are 1.
- `op_ready` is ignored whenever `op_valid`=0.
- The only path back to LOAD_A is `reset`.

## Timing

- Reset values:
  - `op_a`=0, `op_b`=0, `op_valid`=0.
  - `phase`=LOAD_A.
  - Synchronizer flops=1 and debounced level=1 (released).
  - Debounce counter=0, press pulse=0.
- Latency from `key_n` falling to the press pulse: 2 synchronizer cycles + `DEBOUNCE_CYCLES` cycles, then 1 registered cycle.
- The capture register and `op_valid` update on the edge that samples the press pulse, so they are visible the cycle after the pulse.
- `sw` is sampled only on that edge, and any value is legal.
- Handshake boundary: if `op_ready` is already 1 when `op_valid` rises, the transfer completes on the next edge. `op_valid` is therefore high for exactly one cycle.
- Bounce shorter than `DEBOUNCE_CYCLES` produces no event. A held key produces exactly one event.
- An asynchronous `reset` mid-debounce or mid-OFFER returns every register to its reset value immediately.
- After `reset` is released with the key held down, a press event follows once the full debounce period has elapsed.

## Structure

- Package `key_entry_pkg` holds:
  - the FSM state type and encodings (LOAD_A..LOADED);
  - the `phase` width constant;
  - the default `DEBOUNCE_CYCLES`.
- Sub-module `key_debounce` contains the synchronizer, the debounce counter and the falling-edge pulse.
  - Parameter: `DEBOUNCE_CYCLES`.
  - Ports: `clk`, `reset`, `key_n`, `press`.
  - The counter width is derived from `DEBOUNCE_CYCLES`.
- The top level holds the FSM and the operand registers.

## Test plan

All scenarios run with `DEBOUNCE_CYCLES`=4.

- Reset check: assert `reset` with the key pressed → all outputs 0, `phase`=0. Release `reset` → one press event after the debounce period, `op_a`=`sw`.
- First pair:
  - `sw`=0x3C, clean press → `op_a`=0x3C, `phase`=1, `op_valid`=0.
  - `sw`=0xA5, press → `op_b`=0xA5, `op_valid`=1, `phase`=2.
  - `op_ready` 1 for one cycle → `op_valid`=0, `phase`=3.
- Bounce rejection: toggle `key_n` every 2 cycles for 20 cycles, then hold low → exactly one capture. A held key produces no repeat.
- Backpressure:
  - Hold `op_ready`=0 for 50 cycles in OFFER and press again with `sw`=0xFF → `op_b` stays 0xA5 and `op_valid` stays 1.
  - Then raise `op_ready` → transfer occurs with 0xA5.
- Reload B: in LOADED, `sw`=0x01, press → `op_b`=0x01 and `op_a` is unchanged at 0x3C. With `op_ready` tied to 1, `op_valid` is high for exactly 1 cycle.
- Reset mid-OFFER: assert `reset` asynchronously between clock edges → outputs clear before the next edge, `phase`=LOAD_A.
